pellet_tracker: RTL and testbench

- Sits directly downstream of the Pac-Man movement stage and consumes its registered 10-bit block index (32x32 grid, index = row*32 + col).
- Keeps a 1024-bit pellet bitmap and clears the pellet under Pac-Man whenever he enters a new block.
- Maintains the score and the remaining-pellet count, and flags level completion.
- Provides a registered read port so the VGA renderer can decide whether to draw a pellet.

---
 rtl/pellet_tracker_pkg.sv | 42 ++++
 rtl/pellet_tracker_if.sv | 52 +++++
 rtl/pellet_tracker_popcount32.sv | 16 +
 rtl/pellet_tracker.sv | 168 ++++++++++++++++
 tb/tb_pellet_tracker.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pellet_tracker_pkg.sv
// Shared types and constants for the pellet tracker.
// PELLET_TRACKER_POWER_EN adds the power-pellet block list.
package pacman_pkg;

  localparam int GRID_COLS = 32;
  localparam int GRID_ROWS = 32;
  localparam int BLOCK_W   = 10;

  typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] map_t;

  // Full border rows plus four pellets in every inner row
  localparam map_t PELLET_MAP = {
    32'hFFFF_FFFF,
    {30{32'h8001_8001}},
    32'hFFFF_FFFF
  };

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_CHECK,
    S_DONE
  } pellet_state_t;

`ifdef PELLET_TRACKER_POWER_EN
  localparam logic [3:0][BLOCK_W-1:0] POWER_BLOCKS = {
    10'd33, 10'd62, 10'd961, 10'd990
  };

  function automatic logic is_power_block(
    input logic [BLOCK_W-1:0] b
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (POWER_BLOCKS[i] == b) hit = 1'b1;
    end
    return hit;
  endfunction
`endif

endpackage

// File: rtl/pellet_tracker_if.sv
// Bundle between the tracker, the movement stage and the renderer.
// PELLET_TRACKER_POWER_EN adds frame_tick and power_mode.
interface pellet_tracker_if
  import pacman_pkg::*;
#(
  parameter int SCORE_W = 16
);

  logic [BLOCK_W-1:0] pac_block;
  logic [BLOCK_W-1:0] rd_block;
  logic               rd_pellet;
  logic [SCORE_W-1:0] score;
  logic [BLOCK_W-1:0] pellets_left;
  logic               eat_pulse;
  logic               level_done;
  logic               ready;
`ifdef PELLET_TRACKER_POWER_EN
  logic               frame_tick;
  logic               power_mode;
`endif

  modport master (
    output pac_block,
    output rd_block,
`ifdef PELLET_TRACKER_POWER_EN
    output frame_tick,
    input  power_mode,
`endif
    input  rd_pellet,
    input  score,
    input  pellets_left,
    input  eat_pulse,
    input  level_done,
    input  ready
  );

  modport slave (
    input  pac_block,
    input  rd_block,
`ifdef PELLET_TRACKER_POWER_EN
    input  frame_tick,
    output power_mode,
`endif
    output rd_pellet,
    output score,
    output pellets_left,
    output eat_pulse,
    output level_done,
    output ready
  );

endinterface

// File: rtl/pellet_tracker_popcount32.sv
// Population count of one 32-bit bitmap row.
// Used while loading the pellet map.
module popcount32 (
  input  logic [31:0] i_vec,
  output logic [5:0]  o_cnt
);

  // Sum the set bits of the row
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      o_cnt = o_cnt + 6'(i_vec[i]);
    end
  end

endmodule

// File: rtl/pellet_tracker.sv
// Pellet bitmap, score and level tracking for Pac-Man.
// PELLET_TRACKER_POWER_EN enables power pellets and power_mode.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int   SCORE_W     = 16,
  parameter int   PELLET_PTS  = 10,
  parameter int   START_BLOCK = 495,
  parameter map_t MAP         = PELLET_MAP
) (
  input logic             clk,
  input logic             reset,
  pellet_tracker_if.slave bus
);

  localparam logic [BLOCK_W-1:0] START_B =
    BLOCK_W'(START_BLOCK);
  localparam logic [32:0] SCORE_MAX =
    33'((64'd1 << SCORE_W) - 64'd1);

  pellet_state_t r_state;
  pellet_state_t w_next;

  logic [31:0]        r_pel [GRID_ROWS];
  logic [4:0]         r_row_cnt;
  logic [BLOCK_W-1:0] r_last;
  logic [BLOCK_W-1:0] r_chk;
  logic [SCORE_W-1:0] r_score;
  logic [BLOCK_W-1:0] r_left;
  logic               r_eat;
  logic               r_done;
  logic               r_ready;
  logic               r_rd;

  logic [31:0]        w_mask;
  logic [31:0]        w_row;
  logic [5:0]         w_pop;
  logic               w_move;
  logic               w_hit;
  logic [32:0]        w_pts;
  logic [32:0]        w_sum;
  logic [SCORE_W-1:0] w_score_nx;

  assign w_move = (bus.pac_block != r_last);
  assign w_hit  = r_pel[r_chk[9:5]][r_chk[4:0]];

  assign w_mask = (r_row_cnt == START_B[9:5]) ?
                  (32'd1 << START_B[4:0]) : 32'd0;
  assign w_row  = MAP[r_row_cnt] & ~w_mask;

  popcount32 u_pop (
    .i_vec (w_row),
    .o_cnt (w_pop)
  );

`ifdef PELLET_TRACKER_POWER_EN
  logic       w_pwr_hit;
  logic [9:0] r_pwr;

  assign w_pwr_hit = is_power_block(r_chk);
  assign w_pts     = w_pwr_hit ? 33'd50 : 33'(PELLET_PTS);
`else
  assign w_pts     = 33'(PELLET_PTS);
`endif

  assign w_sum      = 33'(r_score) + w_pts;
  assign w_score_nx = (w_sum > SCORE_MAX) ?
                      '1 : w_sum[SCORE_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:  if (r_row_cnt == 5'd31) w_next = S_IDLE;
      S_IDLE:  if (w_move) w_next = S_CHECK;
      S_CHECK: begin
        if (w_hit && r_left == 10'd1) w_next = S_DONE;
        else                          w_next = S_IDLE;
      end
      S_DONE:  w_next = S_DONE;
      default: w_next = S_INIT;
    endcase
  end

  // Counters, score and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_cnt <= '0;
      r_last    <= START_B;
      r_chk     <= '0;
      r_score   <= '0;
      r_left    <= '0;
      r_eat     <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_eat   <= 1'b0;
      r_ready <= (r_state != S_INIT);
      unique case (r_state)
        S_INIT: begin
          r_row_cnt <= r_row_cnt + 5'd1;
          r_left    <= r_left + 10'(w_pop);
        end
        S_IDLE: begin
          if (w_move) begin
            r_chk  <= bus.pac_block;
            r_last <= bus.pac_block;
          end
        end
        S_CHECK: begin
          if (w_hit) begin
            r_eat   <= 1'b1;
            r_score <= w_score_nx;
            r_left  <= r_left - 10'd1;
            if (r_left == 10'd1) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bitmap load during init and clear on eat
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < GRID_ROWS; i++) r_pel[i] <= '0;
    end else if (r_state == S_INIT) begin
      r_pel[r_row_cnt] <= w_row;
    end else if (r_state == S_CHECK && w_hit) begin
      r_pel[r_chk[9:5]][r_chk[4:0]] <= 1'b0;
    end
  end

  // Renderer read port
  always_ff @(posedge clk) begin
    if (reset) r_rd <= 1'b0;
    else       r_rd <= r_pel[bus.rd_block[9:5]][bus.rd_block[4:0]];
  end

`ifdef PELLET_TRACKER_POWER_EN
  // Power timer: reload on power pellet, count down per frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwr <= '0;
    end else if (r_state == S_CHECK && w_hit && w_pwr_hit) begin
      r_pwr <= 10'd600;
    end else if (bus.frame_tick && r_pwr != '0) begin
      r_pwr <= r_pwr - 10'd1;
    end
  end

  assign bus.power_mode = (r_pwr != '0);
`endif

  assign bus.rd_pellet    = r_rd;
  assign bus.score        = r_score;
  assign bus.pellets_left = r_left;
  assign bus.eat_pulse    = r_eat;
  assign bus.level_done   = r_done;
  assign bus.ready        = r_ready;

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: three instances with different maps,
// a timeline model checked every cycle plus literal checkpoints.
module tb_pellet_tracker;
  import pacman_pkg::*;

  localparam logic [1023:0] MAP_B =
    (1024'd1 << 496) | (1024'd1 << 497);
  localparam logic [1023:0] MAP_C =
    (1024'd1 << 495) | (1024'd1 << 496) | (1024'd1 << 497) |
    (1024'd1 << 498) | (1024'd1 << 499);

  logic clk;
  logic reset;
  logic [9:0] pac [3];
  logic [9:0] rd  [3];

  int total = 0;
  int bad   = 0;

  pellet_tracker_if #(.SCORE_W(16)) bus0 ();
  pellet_tracker_if #(.SCORE_W(16)) bus1 ();
  pellet_tracker_if #(.SCORE_W(5))  bus2 ();

  pellet_tracker #(
    .SCORE_W(16), .PELLET_PTS(10), .START_BLOCK(495),
    .MAP(PELLET_MAP)
  ) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  pellet_tracker #(
    .SCORE_W(16), .PELLET_PTS(10), .START_BLOCK(495),
    .MAP(MAP_B)
  ) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  pellet_tracker #(
    .SCORE_W(5), .PELLET_PTS(14), .START_BLOCK(495),
    .MAP(MAP_C)
  ) u2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus0.pac_block = pac[0];
  assign bus1.pac_block = pac[1];
  assign bus2.pac_block = pac[2];
  assign bus0.rd_block  = rd[0];
  assign bus1.rd_block  = rd[1];
  assign bus2.rd_block  = rd[2];
`ifdef PELLET_TRACKER_POWER_EN
  assign bus0.frame_tick = 1'b0;
  assign bus1.frame_tick = 1'b0;
  assign bus2.frame_tick = 1'b0;
`endif

  logic [15:0] o_score [3];
  logic [9:0]  o_left  [3];
  logic        o_eat   [3];
  logic        o_done  [3];
  logic        o_ready [3];
  logic        o_rd    [3];

  assign o_score[0] = bus0.score;
  assign o_score[1] = bus1.score;
  assign o_score[2] = 16'(bus2.score);
  assign o_left[0]  = bus0.pellets_left;
  assign o_left[1]  = bus1.pellets_left;
  assign o_left[2]  = bus2.pellets_left;
  assign o_eat[0]   = bus0.eat_pulse;
  assign o_eat[1]   = bus1.eat_pulse;
  assign o_eat[2]   = bus2.eat_pulse;
  assign o_done[0]  = bus0.level_done;
  assign o_done[1]  = bus1.level_done;
  assign o_done[2]  = bus2.level_done;
  assign o_ready[0] = bus0.ready;
  assign o_ready[1] = bus1.ready;
  assign o_ready[2] = bus2.ready;
  assign o_rd[0]    = bus0.rd_pellet;
  assign o_rd[1]    = bus1.rd_pellet;
  assign o_rd[2]    = bus2.rd_pellet;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, one slot per instance
  logic [1023:0] m_map  [3];
  logic [1023:0] m_bits [3];
  int            m_t    [3];
  int            m_score[3];
  int            m_left [3];
  int            m_due  [3];
  logic [9:0]    m_last [3];
  logic [9:0]    m_chk  [3];
  bit            m_eat  [3];
  bit            m_done [3];
  bit            m_ready[3];
  bit            m_rd   [3];
  bit            m_on = 1'b0;
  int            pts [3] = '{10, 10, 14};
  int            smax[3] = '{65535, 65535, 31};

  function automatic int rows_pop(logic [1023:0] m, int n);
    int c;
    c = 0;
    for (int i = 0; i < n * 32; i++) c += int'(m[i]);
    return c;
  endfunction

  initial begin
    m_map[0] = PELLET_MAP;
    m_map[1] = MAP_B;
    m_map[2] = MAP_C;
    for (int k = 0; k < 3; k++) m_map[k][495] = 1'b0;
  end

  // Timeline model: init load, 2-cycle eat latency, read port
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_on       = 1'b1;
        m_t[k]     = 0;
        m_bits[k]  = m_map[k];
        m_score[k] = 0;
        m_left[k]  = 0;
        m_due[k]   = -1;
        m_last[k]  = 10'd495;
        m_chk[k]   = 10'd0;
        m_eat[k]   = 1'b0;
        m_done[k]  = 1'b0;
        m_ready[k] = 1'b0;
        m_rd[k]    = 1'b0;
      end else if (m_on) begin
        m_t[k] = m_t[k] + 1;
        if (int'(rd[k] >> 5) < m_t[k] - 1)
          m_rd[k] = m_bits[k][rd[k]];
        else
          m_rd[k] = 1'b0;
        if (m_t[k] <= 32) m_left[k] = rows_pop(m_map[k], m_t[k]);
        m_ready[k] = (m_t[k] >= 33);
        m_eat[k] = 1'b0;
        if (m_t[k] == m_due[k]) begin
          m_due[k] = -1;
          if (m_bits[k][m_chk[k]]) begin
            m_bits[k][m_chk[k]] = 1'b0;
            m_score[k] = m_score[k] + pts[k];
            if (m_score[k] > smax[k]) m_score[k] = smax[k];
            m_left[k] = m_left[k] - 1;
            m_eat[k] = 1'b1;
            if (m_left[k] == 0) m_done[k] = 1'b1;
          end
        end else if (m_t[k] >= 33 && !m_done[k] &&
                     pac[k] != m_last[k]) begin
          m_last[k] = pac[k];
          m_chk[k]  = pac[k];
          m_due[k]  = m_t[k] + 1;
        end
      end
    end
  end

  task automatic cmp(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (m_on) begin
      for (int k = 0; k < 3; k++) begin
        cmp($sformatf("u%0d_ready", k), int'(o_ready[k]), int'(m_ready[k]));
        cmp($sformatf("u%0d_score", k), int'(o_score[k]), m_score[k]);
        cmp($sformatf("u%0d_left", k), int'(o_left[k]), m_left[k]);
        cmp($sformatf("u%0d_eat", k), int'(o_eat[k]), int'(m_eat[k]));
        cmp($sformatf("u%0d_done", k), int'(o_done[k]), int'(m_done[k]));
        cmp($sformatf("u%0d_rd", k), int'(o_rd[k]), int'(m_rd[k]));
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic move(int a, int b, int c);
    pac[0] = 10'(a);
    pac[1] = 10'(b);
    pac[2] = 10'(c);
    step(4);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pac[k] = 10'd495;
      rd[k]  = 10'd495;
    end
    step(2);
    cmp("rst_score", int'(bus0.score), 0);
    cmp("rst_ready", int'(bus0.ready), 0);
    reset = 1'b0;
    step(12);
    reset = 1'b1;
    step(1);
    cmp("midinit_rst_left", int'(bus0.pellets_left), 0);
    reset = 1'b0;
    step(32);
    cmp("ready_at_32", int'(bus0.ready), 0);
    step(1);
    cmp("ready_at_33", int'(bus0.ready), 1);
    cmp("init_left_u0", int'(bus0.pellets_left), 183);
    cmp("init_left_u1", int'(bus1.pellets_left), 2);
    cmp("init_left_u2", int'(bus2.pellets_left), 4);
    cmp("init_score", int'(bus0.score), 0);
    cmp("start_rd", int'(bus0.rd_pellet), 0);

    rd[0] = 10'd496;
    pac[0] = 10'd496;
    pac[1] = 10'd496;
    pac[2] = 10'd496;
    step(2);
    cmp("eat_pulse_n2", int'(bus0.eat_pulse), 1);
    cmp("eat_score", int'(bus0.score), 10);
    cmp("eat_left", int'(bus0.pellets_left), 182);
    step(1);
    cmp("eat_pulse_off", int'(bus0.eat_pulse), 0);
    cmp("eaten_rd", int'(bus0.rd_pellet), 0);
    step(2);

    move(495, 497, 497);
    cmp("u1_score20", int'(bus1.score), 20);
    cmp("u1_left0", int'(bus1.pellets_left), 0);
    cmp("u1_done", int'(bus1.level_done), 1);
    cmp("u2_score28", int'(bus2.score), 28);
    move(496, 498, 498);
    cmp("revisit_score", int'(bus0.score), 10);
    cmp("u2_sat", int'(bus2.score), 31);
    move(497, 500, 499);
    cmp("u2_sat_hold", int'(bus2.score), 31);
    cmp("u2_done", int'(bus2.level_done), 1);
    move(32, 0, 0);
    cmp("u0_row1", int'(bus0.score), 20);
    cmp("u1_frozen", int'(bus1.score), 20);
    cmp("u1_sticky", int'(bus1.level_done), 1);

    pac[0] = 10'd33;
    step(1);
    pac[0] = 10'd63;
    step(5);
    cmp("b2b_score", int'(bus0.score), 30);
    cmp("b2b_left", int'(bus0.pellets_left), 180);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
